// File: rtl/wb_op_sequencer.sv
// Writeback-side sequencer for TLB and cache maintenance ops: stalls the pipeline,
// drives the TLB/cache request ports, then issues a one-cycle refetch redirect to PC+4.
module wb_op_sequencer #(
    parameter int unsigned WDOG_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    input  logic [2:0]  req_tlb_op,
    input  logic        req_cache_en,
    input  logic        req_cache_sel,
    input  logic [2:0]  req_cache_code,
    input  logic [31:0] req_vaddr,
    input  logic [31:0] req_paddr,
    output logic        busy,
    output logic [2:0]  tlb_req,
    input  logic        tlb_done,
    output logic        ic_op_valid,
    output logic        dc_op_valid,
    input  logic        ic_op_ready,
    input  logic        dc_op_ready,
    input  logic        ic_op_done,
    input  logic        dc_op_done,
    output logic [2:0]  cache_code,
    output logic [31:0] cache_vaddr,
    output logic [31:0] cache_paddr,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        wdog_err
);

    typedef enum logic [2:0] {
        IDLE,
        TLB,
        CREQ,
        CWAIT,
        REDIR,
        HOLD
    } state_t;

    // The wait state aborts on the cycle the count would reach WDOG_MAX.
    localparam logic [7:0] WDOG_LAST = 8'(WDOG_MAX - 1);

    state_t      state_q;
    logic [7:0]  wdog_cnt_q;
    logic        cache_en_q;
    logic        cache_sel_q;
    logic [2:0]  tlb_req_q;
    logic        ic_valid_q;
    logic        dc_valid_q;
    logic [2:0]  cache_code_q;
    logic [31:0] cache_vaddr_q;
    logic [31:0] cache_paddr_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic        wdog_err_q;

    logic sel_ready;
    logic sel_done;
    logic wdog_hit;

    assign sel_ready = cache_sel_q ? dc_op_ready : ic_op_ready;
    assign sel_done  = cache_sel_q ? dc_op_done  : ic_op_done;
    assign wdog_hit  = (wdog_cnt_q == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            wdog_cnt_q       <= '0;
            cache_en_q       <= 1'b0;
            cache_sel_q      <= 1'b0;
            tlb_req_q        <= '0;
            ic_valid_q       <= 1'b0;
            dc_valid_q       <= 1'b0;
            cache_code_q     <= '0;
            cache_vaddr_q    <= '0;
            cache_paddr_q    <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            wdog_err_q       <= 1'b0;
        end else begin
            redirect_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        redirect_pc_q <= req_pc + 32'd4;
                        cache_en_q    <= req_cache_en;
                        cache_sel_q   <= req_cache_sel;
                        cache_code_q  <= req_cache_code;
                        cache_vaddr_q <= req_vaddr;
                        cache_paddr_q <= req_paddr;
                        wdog_cnt_q    <= '0;
                        if (req_tlb_op != 3'b000) begin
                            state_q   <= TLB;
                            tlb_req_q <= req_tlb_op;
                        end else if (req_cache_en) begin
                            state_q    <= CREQ;
                            ic_valid_q <= ~req_cache_sel;
                            dc_valid_q <= req_cache_sel;
                        end else begin
                            state_q          <= REDIR;
                            redirect_valid_q <= 1'b1;
                        end
                    end
                end
                TLB: begin
                    if (tlb_done) begin
                        tlb_req_q  <= '0;
                        wdog_cnt_q <= '0;
                        if (cache_en_q) begin
                            state_q    <= CREQ;
                            ic_valid_q <= ~cache_sel_q;
                            dc_valid_q <= cache_sel_q;
                        end else begin
                            state_q          <= REDIR;
                            redirect_valid_q <= 1'b1;
                        end
                    end else if (wdog_hit) begin
                        tlb_req_q        <= '0;
                        wdog_err_q       <= 1'b1;
                        state_q          <= REDIR;
                        redirect_valid_q <= 1'b1;
                    end else begin
                        wdog_cnt_q <= wdog_cnt_q + 8'd1;
                    end
                end
                CREQ: begin
                    if (sel_ready) begin
                        ic_valid_q <= 1'b0;
                        dc_valid_q <= 1'b0;
                        wdog_cnt_q <= '0;
                        if (sel_done) begin
                            state_q          <= REDIR;
                            redirect_valid_q <= 1'b1;
                        end else begin
                            state_q <= CWAIT;
                        end
                    end else if (wdog_hit) begin
                        ic_valid_q       <= 1'b0;
                        dc_valid_q       <= 1'b0;
                        wdog_err_q       <= 1'b1;
                        state_q          <= REDIR;
                        redirect_valid_q <= 1'b1;
                    end else begin
                        wdog_cnt_q <= wdog_cnt_q + 8'd1;
                    end
                end
                CWAIT: begin
                    if (sel_done) begin
                        state_q          <= REDIR;
                        redirect_valid_q <= 1'b1;
                    end else if (wdog_hit) begin
                        wdog_err_q       <= 1'b1;
                        state_q          <= REDIR;
                        redirect_valid_q <= 1'b1;
                    end else begin
                        wdog_cnt_q <= wdog_cnt_q + 8'd1;
                    end
                end
                REDIR: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    // Wait for writeback to retire the op so it is not accepted twice.
                    if (!req_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy           = ((state_q != IDLE) && (state_q != HOLD)) ||
                            ((state_q == IDLE) && req_valid);
    assign tlb_req        = tlb_req_q;
    assign ic_op_valid    = ic_valid_q;
    assign dc_op_valid    = dc_valid_q;
    assign cache_code     = cache_code_q;
    assign cache_vaddr    = cache_vaddr_q;
    assign cache_paddr    = cache_paddr_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign wdog_err       = wdog_err_q;

endmodule

// File: tb/tb_wb_op_sequencer.sv
// Directed bench for wb_op_sequencer: table of op transactions with hand-computed
// timing, plus hand sequences for HOLD re-acceptance and reset mid-operation.
module tb_wb_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_pc;
    logic [2:0]  req_tlb_op;
    logic        req_cache_en;
    logic        req_cache_sel;
    logic [2:0]  req_cache_code;
    logic [31:0] req_vaddr;
    logic [31:0] req_paddr;
    logic        busy;
    logic [2:0]  tlb_req;
    logic        tlb_done;
    logic        ic_op_valid;
    logic        dc_op_valid;
    logic        ic_op_ready;
    logic        dc_op_ready;
    logic        ic_op_done;
    logic        dc_op_done;
    logic [2:0]  cache_code;
    logic [31:0] cache_vaddr;
    logic [31:0] cache_paddr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        wdog_err;

    always #5 clk = ~clk;

    wb_op_sequencer #(.WDOG_MAX(255)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .req_tlb_op     (req_tlb_op),
        .req_cache_en   (req_cache_en),
        .req_cache_sel  (req_cache_sel),
        .req_cache_code (req_cache_code),
        .req_vaddr      (req_vaddr),
        .req_paddr      (req_paddr),
        .busy           (busy),
        .tlb_req        (tlb_req),
        .tlb_done       (tlb_done),
        .ic_op_valid    (ic_op_valid),
        .dc_op_valid    (dc_op_valid),
        .ic_op_ready    (ic_op_ready),
        .dc_op_ready    (dc_op_ready),
        .ic_op_done     (ic_op_done),
        .dc_op_done     (dc_op_done),
        .cache_code     (cache_code),
        .cache_vaddr    (cache_vaddr),
        .cache_paddr    (cache_paddr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .wdog_err       (wdog_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Cycle indices are relative to the cycle req_valid is first presented; -1 = never.
    typedef struct {
        logic [2:0]  tlb_op;
        logic        cache_en;
        logic        sel;
        logic [2:0]  code;
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic [31:0] paddr;
        int          tlb_done_at;
        int          ready_at;
        int          done_at;
        int          exp_redir;
        int          exp_tlb_first;
        int          exp_tlb_last;
        int          exp_ic_first;
        int          exp_ic_last;
        int          exp_dc_first;
        int          exp_dc_last;
        logic [31:0] exp_pc;
        logic        exp_wdog;
    } vec_t;

    vec_t vecs[7];

    task automatic idle_inputs();
        req_valid      = 1'b0;
        req_pc         = '0;
        req_tlb_op     = '0;
        req_cache_en   = 1'b0;
        req_cache_sel  = 1'b0;
        req_cache_code = '0;
        req_vaddr      = '0;
        req_paddr      = '0;
        tlb_done       = 1'b0;
        ic_op_ready    = 1'b0;
        dc_op_ready    = 1'b0;
        ic_op_done     = 1'b0;
        dc_op_done     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int redir_cyc   = -1;
        int redir_cnt   = 0;
        int tlb_first   = -1;
        int tlb_last    = -1;
        int ic_first    = -1;
        int ic_last     = -1;
        int dc_first    = -1;
        int dc_last     = -1;
        int busy_bad    = 0;
        logic [2:0]  tlb_val = '0;
        logic [31:0] r_pc = '0;
        logic [31:0] r_va = '0;
        logic [31:0] r_pa = '0;
        logic [2:0]  r_code = '0;
        logic        r_wdog = 1'b0;
        logic        exp_busy;
        string       p;
        p = $sformatf("v%0d", idx);
        for (int c = 0; c < 400; c++) begin
            // Fields after cycle 0 are scrambled; the DUT must hold what it latched.
            req_valid      = (redir_cyc < 0);
            req_pc         = (c == 0) ? v.pc : ~v.pc;
            req_tlb_op     = (c == 0) ? v.tlb_op : 3'b111;
            req_cache_en   = (c == 0) ? v.cache_en : 1'b1;
            req_cache_sel  = (c == 0) ? v.sel : ~v.sel;
            req_cache_code = (c == 0) ? v.code : ~v.code;
            req_vaddr      = (c == 0) ? v.vaddr : ~v.vaddr;
            req_paddr      = (c == 0) ? v.paddr : ~v.paddr;
            tlb_done       = (c == v.tlb_done_at);
            // Unselected cache is held ready/done to show it is ignored.
            ic_op_ready = v.sel ? 1'b1 : (c == v.ready_at);
            ic_op_done  = v.sel ? 1'b1 : (c == v.done_at);
            dc_op_ready = v.sel ? (c == v.ready_at) : 1'b1;
            dc_op_done  = v.sel ? (c == v.done_at) : 1'b1;
            @(negedge clk);
            if (tlb_req != 3'b000) begin
                if (tlb_first < 0) tlb_first = c;
                tlb_last = c;
                tlb_val  = tlb_req;
            end
            if (ic_op_valid) begin
                if (ic_first < 0) ic_first = c;
                ic_last = c;
            end
            if (dc_op_valid) begin
                if (dc_first < 0) dc_first = c;
                dc_last = c;
            end
            if (redirect_valid) begin
                redir_cnt++;
                if (redir_cyc < 0) begin
                    redir_cyc = c;
                    r_pc   = redirect_pc;
                    r_va   = cache_vaddr;
                    r_pa   = cache_paddr;
                    r_code = cache_code;
                    r_wdog = wdog_err;
                end
            end
            exp_busy = (redir_cyc < 0) || (c == redir_cyc);
            if (busy !== exp_busy) busy_bad++;
            next_cycle();
            if (redir_cyc >= 0 && c >= redir_cyc + 2) break;
        end
        idle_inputs();
        check({p, " redirect_cycle"}, 32'(redir_cyc), 32'(v.exp_redir));
        check({p, " redirect_count"}, 32'(redir_cnt), 32'd1);
        check({p, " redirect_pc"}, r_pc, v.exp_pc);
        check({p, " tlb_first"}, 32'(tlb_first), 32'(v.exp_tlb_first));
        check({p, " tlb_last"}, 32'(tlb_last), 32'(v.exp_tlb_last));
        if (v.exp_tlb_first >= 0) check({p, " tlb_req_value"}, 32'(tlb_val), 32'(v.tlb_op));
        check({p, " ic_valid_first"}, 32'(ic_first), 32'(v.exp_ic_first));
        check({p, " ic_valid_last"}, 32'(ic_last), 32'(v.exp_ic_last));
        check({p, " dc_valid_first"}, 32'(dc_first), 32'(v.exp_dc_first));
        check({p, " dc_valid_last"}, 32'(dc_last), 32'(v.exp_dc_last));
        check({p, " cache_code"}, 32'(r_code), 32'(v.code));
        check({p, " cache_vaddr"}, r_va, v.vaddr);
        check({p, " cache_paddr"}, r_pa, v.paddr);
        check({p, " wdog_err"}, 32'(r_wdog), 32'(v.exp_wdog));
        check({p, " busy_bad_cycles"}, 32'(busy_bad), 32'd0);
    endtask

    initial begin
        int redirs;
        int first_r;
        int second_r;
        int busy_bad;
        logic [31:0] second_pc;
        logic        exp_busy;

        //        tlb     cen   sel   code  pc             vaddr          paddr          tdn rdy dn  redir tf tl  if  il  df  dl  exp_pc         wdog
        vecs[0] = '{3'b100, 1'b0, 1'b0, 3'd0, 32'hBFC0_0100, 32'h0000_0000, 32'h0000_0000, 1, -1, -1, 2,   1, 1, -1, -1, -1, -1, 32'hBFC0_0104, 1'b0};
        vecs[1] = '{3'b000, 1'b1, 1'b1, 3'd1, 32'h0000_2000, 32'h8000_1000, 32'h0000_1000, -1, 3, 6, 7,  -1, -1, -1, -1, 1, 3,  32'h0000_2004, 1'b0};
        vecs[2] = '{3'b001, 1'b1, 1'b0, 3'd4, 32'h1000_0000, 32'hA000_0040, 32'h0000_0040, 2, 3, 3, 4,   1, 2, 3, 3, -1, -1,    32'h1000_0004, 1'b0};
        vecs[3] = '{3'b000, 1'b0, 1'b0, 3'd0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, -1, -1, -1, 1, -1, -1, -1, -1, -1, -1, 32'h0000_0000, 1'b0};
        vecs[4] = '{3'b000, 1'b1, 1'b0, 3'd2, 32'h0040_0000, 32'h8000_0200, 32'h0000_0200, -1, 1, 1, 2,  -1, -1, 1, 1, -1, -1,  32'h0040_0004, 1'b0};
        vecs[5] = '{3'b010, 1'b0, 1'b0, 3'd0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 4, -1, -1, 5,  1, 4, -1, -1, -1, -1,  32'h0000_0014, 1'b0};
        vecs[6] = '{3'b000, 1'b1, 1'b1, 3'd5, 32'h8000_0000, 32'h8000_3000, 32'h0000_3000, -1, 1, -1, 257, -1, -1, -1, -1, 1, 1, 32'h8000_0004, 1'b1};

        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset tlb_req", 32'(tlb_req), 32'd0);
        check("reset redirect_pc", redirect_pc, 32'd0);
        check("reset valids", 32'({ic_op_valid, dc_op_valid, redirect_valid, wdog_err}), 32'd0);
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset while waiting in CWAIT for dcache done.
        for (int c = 0; c < 7; c++) begin
            idle_inputs();
            req_valid      = (c <= 2);
            req_cache_en   = 1'b1;
            req_cache_sel  = 1'b1;
            req_cache_code = 3'd3;
            req_pc         = 32'h0000_4000;
            req_vaddr      = 32'h8000_4000;
            req_paddr      = 32'h0000_4000;
            dc_op_ready    = (c == 1);
            dc_op_done     = (c == 5);
            reset          = (c == 3);
            @(negedge clk);
            if (c == 2) begin
                check("rst_seq cwait dc_valid", 32'(dc_op_valid), 32'd0);
                check("rst_seq cwait busy", 32'(busy), 32'd1);
            end
            if (c == 4) begin
                check("rst_seq busy", 32'(busy), 32'd0);
                check("rst_seq outputs", 32'({tlb_req, ic_op_valid, dc_op_valid, redirect_valid, wdog_err, cache_code}), 32'd0);
                check("rst_seq cache_vaddr", cache_vaddr, 32'd0);
                check("rst_seq cache_paddr", cache_paddr, 32'd0);
                check("rst_seq redirect_pc", redirect_pc, 32'd0);
            end
            if (c == 6) check("rst_seq stale done ignored", 32'(redirect_valid), 32'd0);
            next_cycle();
        end
        idle_inputs();

        // req_valid held in HOLD, then a fresh op after it drops.
        redirs = 0; first_r = -1; second_r = -1; busy_bad = 0; second_pc = '0;
        for (int c = 0; c < 12; c++) begin
            idle_inputs();
            req_valid  = (c <= 4) || (c >= 7 && c <= 9);
            req_pc     = (c < 7) ? 32'h2000_0000 : 32'h3000_0000;
            req_tlb_op = (c >= 7) ? 3'b100 : 3'b000;
            tlb_done   = (c == 8);
            @(negedge clk);
            if (redirect_valid) begin
                redirs++;
                if (first_r < 0) first_r = c;
                else if (second_r < 0) begin
                    second_r  = c;
                    second_pc = redirect_pc;
                end
            end
            exp_busy = (c <= 1) || (c >= 7 && c <= 9);
            if (busy !== exp_busy) busy_bad++;
            next_cycle();
        end
        idle_inputs();
        check("hold redirect_count", 32'(redirs), 32'd2);
        check("hold first_redirect", 32'(first_r), 32'd1);
        check("hold second_redirect", 32'(second_r), 32'd9);
        check("hold second_pc", second_pc, 32'h3000_0004);
        check("hold busy_bad_cycles", 32'(busy_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
